grant_ack_gen: RTL

Client-side E-channel GrantAck generator for the TIDC L1 adapter; the counterpart of the L2 sink ID manager. It watches the D channel for Grant/GrantData responses and captures each response's `d_sink`. It queues the captured IDs in order and returns each one on the E channel as a GrantAck, so the manager side can free that sink ID. It throttles D acceptance when its pending-ack queue is full.

---
 rtl/grant_ack_gen.sv | 70 +++++++
 1 files changed

// File: rtl/grant_ack_gen.sv
// grant_ack_gen: captures d_sink of Grant/GrantData on D and returns it in order as a GrantAck on E
`ifndef WSINK
`define WSINK 4
`endif
module grant_ack_gen #(
  parameter int SINK_W = `WSINK,
  parameter int DEPTH  = 4,
  parameter int BEATS  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       d_valid,
  input  logic [2:0]                 d_opcode,
  input  logic [SINK_W-1:0]          d_sink,
  input  logic                       d_ready_in,
  output logic                       d_ready,
  output logic                       e_valid,
  output logic [SINK_W-1:0]          e_sink,
  input  logic                       e_ready,
  output logic [$clog2(DEPTH):0]     pending_cnt,
  output logic                       dup_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  logic [SINK_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr, r_rd;
  logic [AW:0]       r_cnt;
  logic [BW-1:0]     r_beat;
  logic              r_dup;
  logic              w_last, w_full, w_empty, w_enq_beat, w_fire, w_enq, w_deq, w_dup;
  assign w_last     = (BEATS == 1) || (r_beat == BW'(BEATS - 1));
  assign w_full     = r_cnt == (AW+1)'(DEPTH);
  assign w_empty    = r_cnt == '0;
  assign w_enq_beat = d_valid & ((d_opcode == 3'd4) | ((d_opcode == 3'd5) & w_last));
  // Full stalls only enqueuing beats; e_ready deliberately plays no part here
  assign d_ready    = d_ready_in & ~(w_enq_beat & w_full);
  assign w_fire     = d_valid & d_ready;
  assign w_enq      = w_fire & w_enq_beat;
  assign e_valid    = ~w_empty;
  assign e_sink     = r_mem[r_rd];
  assign w_deq      = e_valid & e_ready;
  assign pending_cnt = r_cnt;
  assign dup_err    = r_dup;
  // An entry is live if its distance from rd_ptr is below count, minus the one leaving now
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (({1'b0, AW'(AW'(i) - r_rd)} < r_cnt) && !(w_deq && (AW'(i) == r_rd)) && (r_mem[i] == d_sink))
        w_dup = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_beat <= '0;
      r_dup  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_fire && d_opcode == 3'd5) r_beat <= w_last ? '0 : r_beat + BW'(1);
      if (w_enq) begin
        r_mem[r_wr] <= d_sink;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_deq) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_enq) - (AW+1)'(w_deq);
      r_dup <= w_enq & w_dup;
    end
  end
endmodule
